// File: rtl/alu_issue_if.sv
// Issue-stage bundle: instruction/operand input handshake and decoded ALU op output handshake.
// The slave side is the issue block. The master side is the upstream/downstream environment.
interface alu_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  op;
  logic [31:0] rv1;
  logic [31:0] rv2;
  logic [4:0]  rd;
  logic        wr_en;
  logic        illegal;
  logic [15:0] illegal_count;

  modport master (
    output in_valid, instr, rs1_val, rs2_val, out_ready,
    input  in_ready, out_valid, op, rv1, rv2, rd, wr_en, illegal, illegal_count
  );

  modport slave (
    input  in_valid, instr, rs1_val, rs2_val, out_ready,
    output in_ready, out_valid, op, rv1, rv2, rd, wr_en, illegal, illegal_count
  );
endinterface

// File: rtl/alu_issue.sv
// RV32I OP/OP-IMM decode into a single registered issue slot with valid/ready on both sides.
// Unsupported encodings are issued as zeroed "illegal" ops and counted with saturation.
module alu_issue (
  input  logic        clk,
  input  logic        reset,
  alu_issue_if.slave  bus
);
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] F7_ZERO    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        legal;
  logic [5:0]  op_next;
  logic [31:0] rv1_next;
  logic [31:0] rv2_next;
  logic [4:0]  rd_next;
  logic        wr_en_next;
  logic        illegal_next;

  logic        out_valid_reg;
  logic [5:0]  op_reg;
  logic [31:0] rv1_reg;
  logic [31:0] rv2_reg;
  logic [4:0]  rd_reg;
  logic        wr_en_reg;
  logic        illegal_reg;
  logic [15:0] illegal_count_reg;

  logic        in_fire;
  logic        out_fire;

  assign opcode = bus.instr[6:0];
  assign funct3 = bus.instr[14:12];
  assign funct7 = bus.instr[31:25];
  assign rd_next = bus.instr[11:7];

  always_comb begin
    legal    = 1'b0;
    op_next  = 6'd0;
    rv1_next = bus.rs1_val;
    rv2_next = {{20{bus.instr[31]}}, bus.instr[31:20]};
    case (opcode)
      OPC_OP_IMM: begin
        case (funct3)
          3'b000: begin legal = 1'b1; op_next = 6'b000000; end
          3'b010: begin legal = 1'b1; op_next = 6'b000001; end
          3'b011: begin legal = 1'b1; op_next = 6'b000010; end
          3'b100: begin legal = 1'b1; op_next = 6'b000011; end
          3'b110: begin legal = 1'b1; op_next = 6'b000100; end
          3'b111: begin legal = 1'b1; op_next = 6'b000101; end
          3'b001: begin
            legal    = (funct7 == F7_ZERO);
            op_next  = 6'b000110;
            rv2_next = {27'd0, bus.instr[24:20]};
          end
          default: begin
            // funct3 101: SRLI/SRAI distinguished by funct7
            legal    = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
            op_next  = (funct7 == F7_ALT) ? 6'b001000 : 6'b000111;
            rv2_next = {27'd0, bus.instr[24:20]};
          end
        endcase
      end
      OPC_OP: begin
        rv2_next = bus.rs2_val;
        if (funct7 == F7_ZERO) begin
          legal = 1'b1;
          case (funct3)
            3'b000:  op_next = 6'b001001;
            3'b001:  op_next = 6'b001011;
            3'b010:  op_next = 6'b001100;
            3'b011:  op_next = 6'b001101;
            3'b100:  op_next = 6'b001110;
            3'b101:  op_next = 6'b001111;
            3'b110:  op_next = 6'b010001;
            default: op_next = 6'b010010;
          endcase
        end else if (funct7 == F7_ALT) begin
          case (funct3)
            3'b000:  begin legal = 1'b1; op_next = 6'b001010; end
            3'b101:  begin legal = 1'b1; op_next = 6'b010000; end
            default: legal = 1'b0;
          endcase
        end
      end
      default: legal = 1'b0;
    endcase

    if (!legal) begin
      op_next  = 6'd0;
      rv1_next = 32'd0;
      rv2_next = 32'd0;
    end
    wr_en_next   = legal && (rd_next != 5'd0);
    illegal_next = !legal;
  end

  assign bus.in_ready = !out_valid_reg || bus.out_ready;
  assign in_fire      = bus.in_valid && bus.in_ready;
  assign out_fire     = out_valid_reg && bus.out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_reg     <= 1'b0;
      op_reg            <= 6'd0;
      rv1_reg           <= 32'd0;
      rv2_reg           <= 32'd0;
      rd_reg            <= 5'd0;
      wr_en_reg         <= 1'b0;
      illegal_reg       <= 1'b0;
      illegal_count_reg <= 16'd0;
    end else if (in_fire) begin
      // Covers the simultaneous in/out case: the slot is simply overwritten.
      out_valid_reg <= 1'b1;
      op_reg        <= op_next;
      rv1_reg       <= rv1_next;
      rv2_reg       <= rv2_next;
      rd_reg        <= rd_next;
      wr_en_reg     <= wr_en_next;
      illegal_reg   <= illegal_next;
      if (illegal_next && (illegal_count_reg != 16'hFFFF))
        illegal_count_reg <= illegal_count_reg + 16'd1;
    end else if (out_fire) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign bus.out_valid     = out_valid_reg;
  assign bus.op            = op_reg;
  assign bus.rv1           = rv1_reg;
  assign bus.rv2           = rv2_reg;
  assign bus.rd            = rd_reg;
  assign bus.wr_en         = wr_en_reg;
  assign bus.illegal       = illegal_reg;
  assign bus.illegal_count = illegal_count_reg;
endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: decode vector table, a stalled four-deep stream,
// and an asynchronous reset landing on a held operation.
module tb_alu_issue;
  logic clk;
  logic reset;
  alu_issue_if ifc ();

  alu_issue dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [5:0]  op;
    logic [31:0] rv1;
    logic [31:0] rv2;
    logic [4:0]  rd;
    logic        wr;
    logic        ill;
    logic [15:0] cnt;
  } vec_t;

  localparam int NV = 15;
  vec_t tbl [NV];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_out_valid"}, 32'(ifc.out_valid), 32'd0);
    chk({tag, "_op"},        32'(ifc.op), 32'd0);
    chk({tag, "_rv1"},       ifc.rv1, 32'd0);
    chk({tag, "_rv2"},       ifc.rv2, 32'd0);
    chk({tag, "_rd"},        32'(ifc.rd), 32'd0);
    chk({tag, "_wr_en"},     32'(ifc.wr_en), 32'd0);
    chk({tag, "_illegal"},   32'(ifc.illegal), 32'd0);
    chk({tag, "_count"},     32'(ifc.illegal_count), 32'd0);
  endtask

  initial begin
    int sent;
    int recv;
    int cyc;
    logic [31:0] item;

    //          instr         rs1           rs2          op      rv1           rv2           rd     wr ill cnt
    tbl[0]  = '{32'hFFF00093, 32'h0,        32'h55,      6'h00, 32'h0,        32'hFFFFFFFF, 5'd1,  1, 0, 16'd0};
    tbl[1]  = '{32'h402081B3, 32'd10,       32'd3,       6'h0A, 32'd10,       32'd3,        5'd3,  1, 0, 16'd0};
    tbl[2]  = '{32'h40435293, 32'h80000000, 32'h99,      6'h08, 32'h80000000, 32'h4,        5'd5,  1, 0, 16'd0};
    tbl[3]  = '{32'h00000073, 32'h1234,     32'h5678,    6'h00, 32'h0,        32'h0,        5'd0,  0, 1, 16'd1};
    tbl[4]  = '{32'h00000013, 32'd7,        32'd9,       6'h00, 32'd7,        32'h0,        5'd0,  0, 0, 16'd1};
    tbl[5]  = '{32'h0051B113, 32'd3,        32'd0,       6'h02, 32'd3,        32'd5,        5'd2,  1, 0, 16'd1};
    tbl[6]  = '{32'h01F09213, 32'hAAAA,     32'd0,       6'h06, 32'hAAAA,     32'h1F,       5'd4,  1, 0, 16'd1};
    tbl[7]  = '{32'h41F09213, 32'hAAAA,     32'd0,       6'h00, 32'h0,        32'h0,        5'd4,  0, 1, 16'd2};
    tbl[8]  = '{32'h009473B3, 32'hF0F0,     32'h0FF0,    6'h12, 32'hF0F0,     32'h0FF0,     5'd7,  1, 0, 16'd2};
    tbl[9]  = '{32'h403150B3, 32'hFFFFFFF8, 32'd2,       6'h10, 32'hFFFFFFF8, 32'd2,        5'd1,  1, 0, 16'd2};
    tbl[10] = '{32'h40316033, 32'd1,        32'd2,       6'h00, 32'h0,        32'h0,        5'd0,  0, 1, 16'd3};
    tbl[11] = '{32'hFF05F513, 32'h1234,     32'd0,       6'h05, 32'h1234,     32'hFFFFFFF0, 5'd10, 1, 0, 16'd3};
    tbl[12] = '{32'h007342B3, 32'd5,        32'd6,       6'h0E, 32'd5,        32'd6,        5'd5,  1, 0, 16'd3};
    tbl[13] = '{32'h00135313, 32'd8,        32'd0,       6'h07, 32'd8,        32'd1,        5'd6,  1, 0, 16'd3};
    tbl[14] = '{32'h000000B7, 32'd8,        32'd0,       6'h00, 32'h0,        32'h0,        5'd1,  0, 1, 16'd4};

    reset         = 1'b1;
    ifc.in_valid  = 1'b0;
    ifc.instr     = 32'd0;
    ifc.rs1_val   = 32'd0;
    ifc.rs2_val   = 32'd0;
    ifc.out_ready = 1'b0;
    #1;
    chk_zero_outputs("reset");
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_in_ready", 32'(ifc.in_ready), 32'd1);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      ifc.in_valid  = 1'b1;
      ifc.out_ready = 1'b1;
      ifc.instr     = tbl[i].instr;
      ifc.rs1_val   = tbl[i].rs1;
      ifc.rs2_val   = tbl[i].rs2;
      @(posedge clk);
      #1;
      ifc.in_valid = 1'b0;
      $display("vec %0d instr=%08h op=%02h rv1=%08h rv2=%08h rd=%0d wr=%0b ill=%0b cnt=%0d",
               i, tbl[i].instr, ifc.op, ifc.rv1, ifc.rv2, ifc.rd, ifc.wr_en, ifc.illegal, ifc.illegal_count);
      chk($sformatf("v%0d_out_valid", i), 32'(ifc.out_valid), 32'd1);
      chk($sformatf("v%0d_op", i),        32'(ifc.op), 32'(tbl[i].op));
      chk($sformatf("v%0d_rv1", i),       ifc.rv1, tbl[i].rv1);
      chk($sformatf("v%0d_rv2", i),       ifc.rv2, tbl[i].rv2);
      chk($sformatf("v%0d_rd", i),        32'(ifc.rd), 32'(tbl[i].rd));
      chk($sformatf("v%0d_wr_en", i),     32'(ifc.wr_en), 32'(tbl[i].wr));
      chk($sformatf("v%0d_illegal", i),   32'(ifc.illegal), 32'(tbl[i].ill));
      chk($sformatf("v%0d_count", i),     32'(ifc.illegal_count), 32'(tbl[i].cnt));
    end

    // Drain the slot before the stream so the first item starts from empty.
    @(negedge clk);
    ifc.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("drain_out_valid", 32'(ifc.out_valid), 32'd0);

    // Stream of ADDI x1,x0,k for k=1..4; downstream stalls three cycles after the first arrives.
    sent = 0;
    recv = 0;
    cyc  = 0;
    while (recv < 4 && cyc < 40) begin
      @(negedge clk);
      ifc.out_ready = !(cyc >= 1 && cyc <= 3);
      ifc.in_valid  = (sent < 4);
      ifc.instr     = ((sent + 1) << 20) | 32'h00000093;
      ifc.rs1_val   = 32'd0;
      #1;
      if (ifc.out_valid) begin
        item = 32'(recv + 1);
        chk($sformatf("stream_rv2_c%0d", cyc), ifc.rv2, item);
        chk($sformatf("stream_op_c%0d", cyc), 32'(ifc.op), 32'd0);
        if (!ifc.out_ready)
          chk($sformatf("stall_in_ready_c%0d", cyc), 32'(ifc.in_ready), 32'd0);
      end
      if (ifc.in_valid && ifc.in_ready)
        sent++;
      if (ifc.out_valid && ifc.out_ready) begin
        $display("stream cyc %0d delivered rv2=%0d", cyc, ifc.rv2);
        recv++;
      end
      cyc++;
    end
    chk("stream_delivered", 32'(recv), 32'd4);
    @(negedge clk);
    ifc.in_valid = 1'b0;
    #1;
    chk("stream_end_out_valid", 32'(ifc.out_valid), 32'd0);

    // Asynchronous reset while an illegal op is held under backpressure.
    @(negedge clk);
    ifc.in_valid  = 1'b1;
    ifc.out_ready = 1'b0;
    ifc.instr     = 32'h00000073;
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
    $display("stall-reset held ill=%0b cnt=%0d", ifc.illegal, ifc.illegal_count);
    chk("held_out_valid", 32'(ifc.out_valid), 32'd1);
    chk("held_count", 32'(ifc.illegal_count), 32'd5);
    #2;
    reset = 1'b1;
    #1;
    chk_zero_outputs("async_reset");
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_reset_in_ready", 32'(ifc.in_ready), 32'd1);

    // First transfer right after reset release.
    ifc.in_valid = 1'b1;
    ifc.instr    = 32'h402081B3;
    ifc.rs1_val  = 32'd10;
    ifc.rs2_val  = 32'd3;
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
    $display("post-reset op=%02h rv1=%0d rv2=%0d rd=%0d", ifc.op, ifc.rv1, ifc.rv2, ifc.rd);
    chk("post_reset_out_valid", 32'(ifc.out_valid), 32'd1);
    chk("post_reset_op", 32'(ifc.op), 32'h0A);
    chk("post_reset_rd", 32'(ifc.rd), 32'd3);
    chk("post_reset_count", 32'(ifc.illegal_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed (32-bit data, 6-bit op, 5-bit register index).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  upstream presents an instruction this cycle.
REQ-005 in_ready  output  1  block accepts the instruction this cycle.
REQ-006 instr  input  32  RV32I instruction word.
REQ-007 rs1_val  input  32  value of register instr[19:15], qualified by in_valid.
REQ-008 rs2_val  input  32  value of register instr[24:20], qualified by in_valid.
REQ-009 out_valid  output  1  issued operation is held on outputs.
REQ-010 out_ready  input  1  downstream ALU/writeback consumes the operation.
REQ-011 op  output  6  ALU op code (encoding per REQ-017/018).
REQ-012 rv1, rv2  output  32 each  ALU operands.
REQ-013 rd  output  5  destination register index.
REQ-014 wr_en  output  1  result is to be written to rd.
REQ-015 illegal  output  1  issued instruction was not a supported ALU instruction.
REQ-016 illegal_count  output  16  saturating count of illegal instructions issued.

Function
REQ-017 OP-IMM (opcode 0010011) by funct3: 000 ADDI=000000, 010 SLTI=000001, 011 SLTIU=000010, 100 XORI=000011, 110 ORI=000100, 111 ANDI=000101, 001 SLLI=000110 (funct7 0000000 only), 101 SRLI=000111 (funct7 0000000) / SRAI=001000 (funct7 0100000).
REQ-018 OP (opcode 0110011): funct7 0000000 -- 000 ADD=001001, 001 SLL=001011, 010 SLT=001100, 011 SLTU=001101, 100 XOR=001110, 101 SRL=001111, 110 OR=010001, 111 AND=010010; funct7 0100000 -- 000 SUB=001010, 101 SRA=010000.
REQ-019 Any other opcode/funct3/funct7 combination SHALL be illegal: op=000000, rv1=0, rv2=0, wr_en=0, illegal=1, rd=instr[11:7].
REQ-020 rv1 SHALL equal rs1_val for all legal instructions.
REQ-021 rv2 SHALL be rs2_val for OP; sign-extended instr[31:20] for non-shift OP-IMM; {27'b0, instr[24:20]} for SLLI/SRLI/SRAI.
REQ-022 rd = instr[11:7]; wr_en = legal AND rd != 0.
REQ-023 Single output register stage: accepted instruction appears on outputs with out_valid=1 on the cycle after the accepting edge (latency 1).
REQ-024 Transfer in occurs when in_valid && in_ready; transfer out when out_valid && out_ready.
REQ-025 in_ready = !out_valid || out_ready (combinational); simultaneous out-transfer and in-transfer SHALL replace the output register with no bubble.
REQ-026 While out_valid && !out_ready, all outputs (op, rv1, rv2, rd, wr_en, illegal) SHALL hold stable; in_ready=0.
REQ-027 out_valid SHALL clear after an out-transfer with no concurrent in-transfer.
REQ-028 illegal_count SHALL increment by 1 on each in-transfer of an illegal instruction and saturate at 0xFFFF.
REQ-029 Inputs are ignored (no state change) when in_valid=0 or in_ready=0.

Reset
REQ-030 On reset assertion, immediately and independent of clk: out_valid=0, op=0, rv1=0, rv2=0, rd=0, wr_en=0, illegal=0, illegal_count=0.
REQ-031 Reset mid-stall SHALL discard the held operation; no transfer counted.
REQ-032 After reset deassertion, in_ready=1 and first in-transfer may occur on the next rising edge.

Verification
REQ-033 instr=0xFFF00093 (ADDI x1,x0,-1), rs1_val=0 -> next cycle op=000000, rv1=0, rv2=0xFFFFFFFF, rd=1, wr_en=1, illegal=0.
REQ-034 instr=0x402081B3 (SUB x3,x1,x2), rs1_val=10, rs2_val=3 -> op=001010, rv1=10, rv2=3, rd=3, wr_en=1.
REQ-035 instr=0x40435293 (SRAI x5,x6,4), rs1_val=0x80000000 -> op=001000, rv2=0x00000004, rd=5.
REQ-036 instr=0x00000073 (ECALL) -> illegal=1, wr_en=0, op=000000, illegal_count 0->1; 0x0000_0013 (ADDI x0) -> wr_en=0, illegal=0.
REQ-037 Back-to-back stream of 4 instructions with out_ready low for 3 cycles after the first -> outputs stable during stall, in_ready=0, all 4 delivered in order, none lost or duplicated.
REQ-038 Assert reset asynchronously while out_valid=1 and out_ready=0 -> out_valid and all outputs 0 before next clk edge; illegal_count=0.
